uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
Byte-stream frame parser that sits directly behind the uart_rx instance and feeds the servo path. It consumes the byte strobe from uart_rx and assembles frames in the same format our transmitter emits: PAYLOAD_BYTES binary payload bytes, MSB byte first, followed by one terminator byte (0x0A). Each good frame is presented as one word with a single-cycle valid pulse. Bad terminators, inter-byte timeouts and line breaks are flagged, and the parser re-synchronises automatically.

Parameters:
PAYLOAD_BYTES, 3, number of payload bytes per frame (range 1..4)
TERMINATOR, 8'h0A, frame terminator byte
TIMEOUT_CYCLES, 270000, maximum i_clk cycles between bytes inside a frame (10 ms at 27 MHz)

Ports:
i_clk  in  1  system clock
i_resetn  in  1  asynchronous active-low reset
i_rx_valid  in  1  one-cycle strobe from uart_rx when i_rx_data is valid
i_rx_data  in  8  received byte
i_rx_break  in  1  break indication from uart_rx
o_frame_data  out  8*PAYLOAD_BYTES  last good payload; first byte received in the MSBs
o_frame_valid  out  1  one-cycle pulse per good frame
o_frame_error  out  1  one-cycle pulse per error event
o_err_code  out  2  cause of the last error: 0 none, 1 BAD_TERM, 2 TIMEOUT, 3 BREAK
o_busy  out  1  high while a frame is partially received (PAYLOAD, TERM or RESYNC)
o_frame_count  out  8  count of good frames, wraps 255->0

Behaviour:
- Reset (asynchronous, i_resetn=0): all outputs 0, state IDLE, byte index 0, shift register 0, gap counter 0.
- IDLE: on i_rx_valid, shift the byte in, set idx=1 and go to PAYLOAD (or TERM if PAYLOAD_BYTES==1).
- PAYLOAD: on i_rx_valid, shift the byte in and increment idx. When idx reaches PAYLOAD_BYTES, go to TERM.
- Payload is binary-transparent: a TERMINATOR value in IDLE or PAYLOAD is stored as data.
- TERM, byte == TERMINATOR: on the next cycle (1-cycle latency from the strobe), o_frame_data <= shift register, o_frame_valid=1 for one cycle, o_frame_count+1; go to IDLE.
- TERM, byte != TERMINATOR: error BAD_TERM; go to RESYNC.
- RESYNC: discard bytes until TERMINATOR is received, then go to IDLE. The discard itself raises no further errors.
- Gap timer: cleared on every i_rx_valid and held at 0 in IDLE and RESYNC. It increments in PAYLOAD and TERM. When it reaches TIMEOUT_CYCLES, raise error TIMEOUT, discard the partial frame and go to IDLE.
- Break: i_rx_break=1 in any state except IDLE raises error BREAK and returns to IDLE. In IDLE a break is ignored with no error. While break is held, no further errors are raised and incoming bytes are dropped.
- Error reporting: o_frame_error pulses for 1 cycle, one cycle after the cause. o_err_code updates on the same cycle and holds until the next error or reset.
- o_frame_data only changes on a good frame. Errors never modify it.
- Simultaneous events in the same cycle:
  - break beats byte, and the byte is dropped;
  - byte beats timeout, and the byte is accepted with the counter cleared;
  - frame_valid and frame_error never assert together.
- o_busy is a registered version of (state != IDLE).
- Arithmetic: shift register width is 8*PAYLOAD_BYTES. Gap counter width is clog2(TIMEOUT_CYCLES+1). Frame count wraps modulo 256.

Decomposition:
- Shared package uart_frame_pkg holds:
  - state encoding: IDLE, PAYLOAD, TERM, RESYNC;
  - error codes: ERR_NONE, ERR_BAD_TERM, ERR_TIMEOUT, ERR_BREAK;
  - default TERMINATOR.
- One sub-module, uart_gap_timer, with inputs clear, enable and limit and a one-cycle expired pulse output. The top FSM instantiates it once.

Test Plan:
1. Good frame: 0x14,0x00,0x00,0x0A -> o_frame_data=0x140000, o_frame_valid high for exactly 1 cycle, one cycle after the 0x0A strobe; o_frame_count=1; o_busy back to 0.
2. Transparent payload: 0x0A,0x0A,0x0A,0x0A -> o_frame_data=0x0A0A0A with one valid pulse. A second identical frame gives o_frame_count=2.
3. Bad terminator and resync: 0x01,0x02,0x03,0x55 -> error pulse with o_err_code=1. Then 0x77,0x0A (discarded) followed by 0xAA,0xBB,0xCC,0x0A -> o_frame_data=0xAABBCC; the earlier data is never output.
4. Timeout (TIMEOUT_CYCLES=100): 0x11,0x22, then silence -> error pulse with code 2 exactly 100 cycles after the 0x22 strobe; o_frame_data unchanged. A following 0x33,0x44,0x55,0x0A gives 0x334455.
5. Break and reset: send 0x11 then assert i_rx_break for 20 cycles -> one error pulse with code 3, state IDLE. Send 0x66,0x77, then assert i_resetn=0 mid-frame -> all outputs 0 immediately, with no clock edge required.
6. Counter wrap and simultaneity: send 256 good frames -> o_frame_count returns to 0. Assert i_rx_valid and i_rx_break in the same cycle during PAYLOAD -> BREAK error and the byte is dropped.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART byte-stream frame parser.
// Holds the parser state encoding, the error cause codes and the default terminator.
package uart_frame_pkg;

    localparam logic [7:0] DEFAULT_TERMINATOR = 8'h0A;
    localparam int unsigned FRAME_COUNT_W     = 8;
    localparam int unsigned ERR_CODE_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TERM    = 2'd2,
        ST_RESYNC  = 2'd3
    } frame_state_e;

    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_TERM = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_BREAK    = 2'd3
    } frame_err_e;

    // The gap timer only runs while a frame is partially assembled.
    function automatic logic in_frame(input frame_state_e st);
        return (st == ST_PAYLOAD) || (st == ST_TERM);
    endfunction

endpackage

// File: rtl/uart_frame_rx_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and flags
// the cycle in which the count is about to reach the limit.
module uart_gap_timer #(
    parameter int unsigned CNT_W = 19
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero when disabled; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_enable) begin
            cnt_d = '0;
        end else if (cnt_q != i_limit) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle wins, so a late byte is never flagged.
    assign o_expired_c = i_enable && !i_clear && (cnt_q == CNT_W'(i_limit - CNT_W'(1)));

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind uart_rx: assembles PAYLOAD_BYTES binary bytes plus a
// terminator into one word, flags bad terminators, gaps and breaks, and resyncs.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 3,
    parameter logic [7:0]  TERMINATOR     = DEFAULT_TERMINATOR,
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_rx_valid,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_break,
    output logic [8*PAYLOAD_BYTES-1:0] o_frame_data,
    output logic                       o_frame_valid,
    output logic                       o_frame_error,
    output logic [ERR_CODE_W-1:0]      o_err_code,
    output logic                       o_busy,
    output logic [FRAME_COUNT_W-1:0]   o_frame_count
);

    localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_e               state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DATA_W-1:0]          shift_q, shift_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       error_q, error_d;
    frame_err_e                 err_code_q, err_code_d;
    logic                       busy_q, busy_d;
    logic [FRAME_COUNT_W-1:0]   count_q, count_d;

    logic                       timer_en_c;
    logic                       timer_expired_c;
    logic [DATA_W-1:0]          shifted_c;
    logic [IDX_W-1:0]           idx_inc_c;

    assign timer_en_c = in_frame(state_q);
    assign shifted_c  = DATA_W'({shift_q, i_rx_data});
    assign idx_inc_c  = IDX_W'(idx_q + IDX_W'(1));

    uart_gap_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_clear     (i_rx_valid),
        .i_enable    (timer_en_c),
        .i_limit     (CNT_W'(TIMEOUT_CYCLES)),
        .o_expired_c (timer_expired_c)
    );

    // Next-state: break beats byte, byte beats timeout.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        count_d    = count_q;

        if (i_rx_break) begin
            if (state_q != ST_IDLE) begin
                error_d    = 1'b1;
                err_code_d = ERR_BREAK;
                state_d    = ST_IDLE;
                idx_d      = '0;
            end
        end else if (i_rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    shift_d = shifted_c;
                    idx_d   = IDX_W'(1);
                    state_d = (PAYLOAD_BYTES == 1) ? ST_TERM : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    shift_d = shifted_c;
                    idx_d   = idx_inc_c;
                    if (idx_inc_c == IDX_W'(PAYLOAD_BYTES)) begin
                        state_d = ST_TERM;
                    end
                end
                ST_TERM: begin
                    idx_d = '0;
                    if (i_rx_data == TERMINATOR) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        count_d = FRAME_COUNT_W'(count_q + FRAME_COUNT_W'(1));
                        state_d = ST_IDLE;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD_TERM;
                        state_d    = ST_RESYNC;
                    end
                end
                ST_RESYNC: begin
                    if (i_rx_data == TERMINATOR) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timer_expired_c) begin
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
            idx_d      = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign o_frame_data  = data_q;
    assign o_frame_valid = valid_q;
    assign o_frame_error = error_q;
    assign o_err_code    = err_code_q;
    assign o_busy        = busy_q;
    assign o_frame_count = count_q;

endmodule
